// File: rtl/mealy_seq_machine.sv
`default_nettype none
// ============================================================================
// Module      : mealy_seq_machine
// Description : Four-way overlapping serial pattern detector (Mealy FSM).
//               Optional saturating hit counters via MEALY_MATCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_seq_machine #(
    parameter logic [3:0] PAT0 = 4'b1101,
    parameter logic [3:0] PAT1 = 4'b1011,
    parameter logic [3:0] PAT2 = 4'b0110,
    parameter logic [3:0] PAT3 = 4'b1001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
`ifdef MEALY_MATCH_COUNT_EN
    input  logic        cnt_clr,
    output logic [31:0] match_cnt,
`endif
    output logic [3:0]  out
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [15:0] c_pats = {PAT3, PAT2, PAT1, PAT0};

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_hist;
    logic [3:0] w_window;
    logic       w_armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_hist  <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= {r_hist[1:0], in};
        end
    end

    // Fill counter: history is only trusted once three real bits are in.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: w_state_nxt = S_ONE;
            S_ONE:   w_state_nxt = S_TWO;
            S_TWO:   w_state_nxt = S_FULL;
            S_FULL:  w_state_nxt = S_FULL;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    assign w_window = {r_hist, in};
    assign w_armed  = reset && (r_state == S_FULL);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            assign out[gi] = w_armed && (w_window == c_pats[gi*4 +: 4]);
        end
    endgenerate

`ifdef MEALY_MATCH_COUNT_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [7:0] r_cnt;

            // Clear takes priority over a same-cycle hit; counts stick at 255.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= 8'd0;
                end else if (cnt_clr) begin
                    r_cnt <= 8'd0;
                end else if (out[gi] && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign match_cnt[gi*8 +: 8] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_seq_machine
// Description : Directed self-checking bench for mealy_seq_machine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_machine;

    logic        r_clk     = 1'b0;
    logic        r_reset   = 1'b0;
    logic        r_in      = 1'b0;
    logic        r_cnt_clr = 1'b0;
    logic [3:0]  w_out;
    logic [3:0]  w_out_dup;
    logic [31:0] w_match_cnt;
    logic [31:0] w_match_cnt_dup;

    int n_checks = 0;
    int n_errors = 0;

    always #5 r_clk = ~r_clk;

    mealy_seq_machine dut (
        .clk       (r_clk),
        .reset     (r_reset),
        .in        (r_in),
`ifdef MEALY_MATCH_COUNT_EN
        .cnt_clr   (r_cnt_clr),
        .match_cnt (w_match_cnt),
`endif
        .out       (w_out)
    );

    mealy_seq_machine #(
        .PAT0 (4'b1101),
        .PAT1 (4'b1101)
    ) dut_dup (
        .clk       (r_clk),
        .reset     (r_reset),
        .in        (r_in),
`ifdef MEALY_MATCH_COUNT_EN
        .cnt_clr   (r_cnt_clr),
        .match_cnt (w_match_cnt_dup),
`endif
        .out       (w_out_dup)
    );

`ifndef MEALY_MATCH_COUNT_EN
    assign w_match_cnt     = 32'd0;
    assign w_match_cnt_dup = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one bit, check out mid-cycle, then let the edge consume it.
    task automatic present(input logic b, input logic [3:0] exp, input string tag);
        r_in = b;
        #2;
        check(tag, {28'd0, w_out}, {28'd0, exp});
        @(posedge r_clk);
        #1;
    endtask

    task automatic feed(input logic b);
        r_in = b;
        @(posedge r_clk);
        #1;
    endtask

    logic       seq_bits [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] seq_exp  [14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001,
                                  4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0100};

    initial begin
        // Held in reset with in=1: outputs stay low across edges.
        r_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge r_clk);
            #1;
            check($sformatf("rst_hold%0d", i), {28'd0, w_out}, 32'd0);
        end
        r_reset = 1'b1;

        // Third bit would hit PAT2 if reset zeros counted as history.
        present(1'b1, 4'b0000, "rel_b0");
        present(1'b1, 4'b0000, "rel_b1");
        present(1'b0, 4'b0000, "rel_b2");
        r_in = 1'b1;
        #2;
        check("dup_both", {28'd0, w_out_dup}, 32'h3);
        present(1'b1, 4'b0001, "rel_b3");

        // Walk history to 110 while full.
        present(1'b1, 4'b0010, "walk_1011");
        present(1'b0, 4'b0100, "walk_0110");

        // Same cycle, no edge: input toggle alone flips the Mealy output.
        r_in = 1'b0;
        #1;
        check("mealy_lo", {28'd0, w_out}, 32'd0);
        r_in = 1'b1;
        #1;
        check("mealy_hi", {28'd0, w_out}, 32'h1);

        r_reset = 1'b0;
        #1;
        check("async_rst", {28'd0, w_out}, 32'd0);
        check("async_rst_dup", {28'd0, w_out_dup}, 32'd0);
        @(posedge r_clk);
        #1;
        r_reset = 1'b1;
        present(1'b1, 4'b0000, "mid_b0");
        present(1'b1, 4'b0000, "mid_b1");
        present(1'b0, 4'b0000, "mid_b2");
        present(1'b1, 4'b0001, "mid_b3");

        // Fresh reset, then the reference stream.
        r_reset = 1'b0;
        #2;
        check("cnt_rst", w_match_cnt, 32'd0);
        r_reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            present(seq_bits[i], seq_exp[i], $sformatf("seq_b%0d", i));
        end

`ifdef MEALY_MATCH_COUNT_EN
        check("cnt_seq", w_match_cnt, {8'd2, 8'd3, 8'd1, 8'd1});

        // Clear coincides with a PAT0 hit: clear must win.
        r_in      = 1'b1;
        r_cnt_clr = 1'b1;
        #1;
        check("clr_hit_out", {28'd0, w_out}, 32'h1);
        @(posedge r_clk);
        #1;
        r_cnt_clr = 1'b0;
        check("cnt_clr", w_match_cnt, 32'd0);

        // Repeating 110 overlaps PAT0/1/2 every period; 400 periods saturate.
        for (int i = 0; i < 400; i++) begin
            feed(1'b1);
            feed(1'b1);
            feed(1'b0);
        end
        check("cnt_sat", w_match_cnt, {8'd0, 8'd255, 8'd255, 8'd255});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mealy_seq_machine.md
Name: mealy_seq_machine

Overview:
- Four-way overlapping serial pattern detector, implemented as a Mealy FSM on a 1-bit serial input sampled once per clock.
- out[3:0] is combinational from current state and the current input. Each bit flags that the last three sampled bits plus the present input equal one of four 4-bit patterns.
- Used as a small control or sequence-recognition leaf block; one instance per serial stream.

Parameters:
- PAT0, 4'b1101, pattern driving out[0]; MSB = oldest bit, LSB = present input.
- PAT1, 4'b1011, pattern driving out[1].
- PAT2, 4'b0110, pattern driving out[2].
- PAT3, 4'b1001, pattern driving out[3].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in  input  1  serial data bit, sampled at each rising clk.
- out  output  4  Mealy match flags, one per pattern.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. No enable: every rising clk while reset=1 consumes one input bit.
- State is hist[2:0] (last three sampled bits, hist[0] newest) plus fill state.
- Fill states and transitions, one per rising edge with reset=1:
  - S_EMPTY -> S_ONE -> S_TWO -> S_FULL.
  - S_FULL -> S_FULL.
- On each rising edge: hist <= {hist[1:0], in}.
- Reset asserted (reset=0), asynchronous: hist=3'b000, state=S_EMPTY, out forced to 4'b0000 for the whole time reset is low.
- out[i] = 1 iff state==S_FULL and {hist[2:0], in} == PATi. Otherwise 0.
- out is purely combinational; no register stage. A change on in while in S_FULL changes out in the same cycle.
- Matching is overlapping: a match does not reset history. For example, 1101101 yields two PAT0 hits.
- Matching is independent per bit: several out bits may be 1 simultaneously if patterns are equal.
- No detection before 3 bits have been sampled since reset release. Prefix zeros from reset are never treated as history.
- Reset deasserted mid-stream: history restarts from S_EMPTY.
- Reset asserted mid-stream: out drops to 0 immediately, without waiting for a clk edge.
- Parameters are independent. Any 4-bit value is legal, including duplicates.

Optional Feature:
- Macro MEALY_MATCH_COUNT_EN.
- When defined, the block adds two ports:
  - cnt_clr (input, 1): synchronous clear of all counters.
  - match_cnt (output, 32): four 8-bit saturating counters packed as {cnt3, cnt2, cnt1, cnt0}.
- cnt_i increments on each rising clk where out[i]=1. It saturates at 255.
- Priority: cnt_clr beats increment. Asynchronous reset sets all counters to 0.
- When not defined: ports and logic are absent. out behaviour is identical in both builds.

Test Plan:
- Reset behaviour: hold reset=0, drive in=1 and toggle clk. Expect out=0000 throughout. Release reset and clock in 1,1,0 with in=1 at the fourth position: out=0001 only after the fourth bit is presented.
- Default sequence: after reset release, clock in 0,1,1,0,1,1,0,0,1,0,0,1,1,0 (bit 0 first). Expected out while each bit is presented:
  - bits 0-2: 0000.
  - bit 3: 0100. bit 4: 0001. bit 5: 0010. bit 6: 0100. bit 7: 0000. bit 8: 1000.
  - bits 9, 10: 0000. bit 11: 1000. bit 12: 0000. bit 13: 0100.
- Mealy timing: in S_FULL with hist=110, toggle in 0->1 mid-cycle with no edge. out goes from 0000 to 0001 combinationally.
- Mid-stream reset: after hist=110 and S_FULL, pulse reset low. out goes to 0 at once. After release, bits 1 then 1 give no match until 4 bits have been collected.
- Simultaneous match: set PAT1=PAT0=4'b1101 and feed 1101. Expect out=0011 on the fourth bit.
- With MEALY_MATCH_COUNT_EN: run the default sequence. Expect match_cnt = {8'd2, 8'd3, 8'd1, 8'd1}. Assert cnt_clr for one cycle and expect all counters 0. Feed 300 back-to-back PAT0 hits (repeat 1101 overlapped); cnt0 must saturate at 255.
